// File: rtl/hazard_forward_unit.sv
// Hazard unit for the pipelined RISC-V core. It handles EX operand forwarding, load-use stalls,
// branch flushes, a mul/div occupancy FSM that freezes the front end, and a saturating stall counter.
module hazard_forward_unit #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [REG_AW-1:0] rd_me,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              RUWr_ex,
  input  logic              RUWr_me,
  input  logic              RUWr_wb,
  input  logic              DMRd_ex,
  input  logic              MD_start_ex,
  input  logic              Branch_taken_ex,
  output logic [1:0]        ForwardASrc,
  output logic [1:0]        ForwardBSrc,
  output logic              Stall_if,
  output logic              Stall_id,
  output logic              Stall_ex,
  output logic              Flush_id,
  output logic              Flush_ex,
  output logic              Flush_me,
  output logic              MD_done,
  output logic [CNT_W-1:0]  Stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_t;

  localparam int CW     = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam int LOAD_I = (MD_LATENCY > 2) ? (MD_LATENCY - 3) : 0;
  localparam logic [CW-1:0] MD_LOAD = CW'(LOAD_I);

  md_state_t     state_r, state_nxt_s;
  logic [CW-1:0] md_cnt_r, md_cnt_nxt_s;
  logic          md_stall_s, branch_s, load_use_s;

  // ME result is younger than WB, so it takes precedence; x0 is hardwired and never forwarded
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              wr_me,
                                         input logic [REG_AW-1:0] dst_me,
                                         input logic              wr_wb,
                                         input logic [REG_AW-1:0] dst_wb);
    logic [1:0] sel;
    if (wr_me && (dst_me == rs) && (dst_me != {REG_AW{1'b0}})) begin
      sel = 2'b01;
    end else if (wr_wb && (dst_wb == rs) && (dst_wb != {REG_AW{1'b0}})) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // mul/div occupancy state and remaining-BUSY-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      md_cnt_r <= {CW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

  // next-state: the held MD_start_ex is only honoured from IDLE
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    case (state_r)
      IDLE: begin
        if (MD_start_ex) begin
          md_cnt_nxt_s = MD_LOAD;
          state_nxt_s  = (MD_LATENCY > 2) ? BUSY : DONE;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      BUSY: begin
        if (md_cnt_r == {CW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          md_cnt_nxt_s = md_cnt_r - CW'(1);
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // hazard decode: MD occupancy beats branch, branch beats load-use
  always_comb begin
    md_stall_s  = 1'b0;
    branch_s    = 1'b0;
    load_use_s  = 1'b0;
    MD_done     = 1'b0;
    ForwardASrc = 2'b00;
    ForwardBSrc = 2'b00;
    if (!rst) begin
      ForwardASrc = fwd_sel(rs1_ex, RUWr_me, rd_me, RUWr_wb, rd_wb);
      ForwardBSrc = fwd_sel(rs2_ex, RUWr_me, rd_me, RUWr_wb, rd_wb);
      md_stall_s  = ((state_r == IDLE) && MD_start_ex) || (state_r == BUSY);
      MD_done     = (state_r == DONE);
      if ((state_r == IDLE) && !MD_start_ex) begin
        branch_s   = Branch_taken_ex;
        load_use_s = !Branch_taken_ex && DMRd_ex && RUWr_ex &&
                     (rd_ex != {REG_AW{1'b0}}) &&
                     ((rd_ex == rs1_id) || (rd_ex == rs2_id));
      end else begin
        branch_s   = 1'b0;
        load_use_s = 1'b0;
      end
    end else begin
      md_stall_s = 1'b0;
    end
  end

  assign Stall_if = md_stall_s | load_use_s;
  assign Stall_id = md_stall_s | load_use_s;
  assign Stall_ex = md_stall_s;
  assign Flush_me = md_stall_s;
  assign Flush_id = branch_s;
  assign Flush_ex = branch_s | load_use_s;

  // saturating count of ID-stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      Stall_cnt <= {CNT_W{1'b0}};
    end else if (Stall_id && (Stall_cnt != {CNT_W{1'b1}})) begin
      Stall_cnt <= Stall_cnt + CNT_W'(1);
    end else begin
      Stall_cnt <= Stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: a default instance (MD_LATENCY=4) and a
// small instance (MD_LATENCY=2, CNT_W=4) share stimulus and are checked against a phase model.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
  logic       RUWr_ex, RUWr_me, RUWr_wb, DMRd_ex, MD_start_ex, Branch_taken_ex;

  logic [1:0]  fa1, fb1, fa2, fb2;
  logic        sif1, sid1, sex1, fid1, fex1, fme1, done1;
  logic        sif2, sid2, sex2, fid2, fex2, fme2, done2;
  logic [31:0] cnt1_o;
  logic [3:0]  cnt2_o;

  wire [10:0] obs1 = {fa1, fb1, sif1, sid1, sex1, fid1, fex1, fme1, done1};
  wire [10:0] obs2 = {fa2, fb2, sif2, sid2, sex2, fid2, fex2, fme2, done2};

  int     n_checks = 0;
  int     n_fail   = 0;
  int     ph1 = 0, ph2 = 0;
  longint cnt1 = 0;
  int     cnt2 = 0;
  logic [10:0] e1, e2;

  always #5 clk = ~clk;

  hazard_forward_unit dut1 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb), .RUWr_ex(RUWr_ex), .RUWr_me(RUWr_me),
    .RUWr_wb(RUWr_wb), .DMRd_ex(DMRd_ex), .MD_start_ex(MD_start_ex),
    .Branch_taken_ex(Branch_taken_ex), .ForwardASrc(fa1), .ForwardBSrc(fb1),
    .Stall_if(sif1), .Stall_id(sid1), .Stall_ex(sex1), .Flush_id(fid1), .Flush_ex(fex1),
    .Flush_me(fme1), .MD_done(done1), .Stall_cnt(cnt1_o));

  hazard_forward_unit #(.REG_AW(5), .MD_LATENCY(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb), .RUWr_ex(RUWr_ex), .RUWr_me(RUWr_me),
    .RUWr_wb(RUWr_wb), .DMRd_ex(DMRd_ex), .MD_start_ex(MD_start_ex),
    .Branch_taken_ex(Branch_taken_ex), .ForwardASrc(fa2), .ForwardBSrc(fb2),
    .Stall_if(sif2), .Stall_id(sid2), .Stall_ex(sex2), .Flush_id(fid2), .Flush_ex(fex2),
    .Flush_me(fme2), .MD_done(done2), .Stall_cnt(cnt2_o));

  // ph = cycles elapsed since the mul/div was accepted (0 = idle)
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RUWr_me && rd_me == rs && rd_me != 5'd0) return 2'b01;
    if (RUWr_wb && rd_wb == rs && rd_wb != 5'd0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model(input int ph, input int lat);
    logic md_stall, done, br, lu, haz;
    if (rst) return 11'd0;
    md_stall = (ph == 0 && MD_start_ex) || (ph >= 1 && ph <= lat - 2);
    done     = (ph >= 1 && ph == lat - 1);
    haz      = DMRd_ex && RUWr_ex && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);
    br       = ph == 0 && !MD_start_ex && Branch_taken_ex;
    lu       = ph == 0 && !MD_start_ex && !Branch_taken_ex && haz;
    return {ref_fwd(rs1_ex), ref_fwd(rs2_ex), md_stall | lu, md_stall | lu, md_stall,
            br, br | lu, md_stall, done};
  endfunction

  function automatic int next_ph(input int ph, input int lat);
    if (rst) return 0;
    if (ph == 0) return MD_start_ex ? 1 : 0;
    if (ph >= lat - 1) return 0;
    return ph + 1;
  endfunction

  task automatic tick();
    logic [10:0] m1, m2;
    m1 = model(ph1, 4);
    m2 = model(ph2, 2);
    @(posedge clk);
    if (rst) begin
      cnt1 = 0; cnt2 = 0;
    end else begin
      if (m1[5] && cnt1 < 64'hFFFF_FFFF) cnt1 = cnt1 + 1;
      if (m2[5] && cnt2 < 15) cnt2 = cnt2 + 1;
    end
    ph1 = next_ph(ph1, 4);
    ph2 = next_ph(ph2, 2);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
    rd_ex = 5'd0; rd_me = 5'd0; rd_wb = 5'd0;
    RUWr_ex = 1'b0; RUWr_me = 1'b0; RUWr_wb = 1'b0;
    DMRd_ex = 1'b0; MD_start_ex = 1'b0; Branch_taken_ex = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick(); tick();
    RUWr_me = 1'b1; rd_me = 5'd3; rs1_ex = 5'd3; MD_start_ex = 1'b1; Branch_taken_ex = 1'b1;
    #2;
    n_checks++;
    if (obs1 !== 11'd0) begin n_fail++; $display("FAIL reset_outputs got %b want 0", obs1); end
    n_checks++;
    if (cnt1_o !== 32'd0 || cnt2_o !== 4'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt1_o, cnt2_o);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward();
    clear_inputs();
    RUWr_me = 1'b1; RUWr_wb = 1'b1; rd_me = 5'd4; rd_wb = 5'd4; rs1_ex = 5'd4; rs2_ex = 5'd11;
    #2;
    n_checks++;
    if (fa1 !== 2'b01 || fb1 !== 2'b00) begin
      n_fail++; $display("FAIL fwd_me_priority got A=%b B=%b want A=01 B=00", fa1, fb1);
    end
    RUWr_me = 1'b0;
    #1;
    n_checks++;
    if (fa1 !== 2'b10) begin n_fail++; $display("FAIL fwd_wb got %b want 10", fa1); end
    RUWr_me = 1'b1; rd_me = 5'd0; rd_wb = 5'd0; rs1_ex = 5'd0;
    #1;
    n_checks++;
    if (fa1 !== 2'b00) begin n_fail++; $display("FAIL fwd_x0 got %b want 00", fa1); end
    tick();
    for (int i = 0; i < 30; i++) begin
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_me = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
      RUWr_me = 1'($urandom_range(0, 1)); RUWr_wb = 1'($urandom_range(0, 1));
      #2;
      e1 = model(ph1, 4);
      n_checks++;
      if (obs1 !== e1) begin n_fail++; $display("FAIL fwd_random got %b want %b", obs1, e1); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    DMRd_ex = 1'b1; RUWr_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs1_id = 5'd9;
    #2;
    n_checks++;
    if ({sif1, sid1, fex1, sex1, fid1} !== 5'b11100) begin
      n_fail++; $display("FAIL load_use_stall got %b want 11100", {sif1, sid1, fex1, sex1, fid1});
    end
    tick();
    clear_inputs();
    #2;
    n_checks++;
    if ({sif1, sid1, fex1} !== 3'b000 || cnt1_o !== 32'd1) begin
      n_fail++; $display("FAIL load_use_after got %b cnt=%0d want 000 cnt=1", {sif1, sid1, fex1}, cnt1_o);
    end
    DMRd_ex = 1'b1; RUWr_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0;
    #1;
    n_checks++;
    if ({sif1, sid1, fex1} !== 3'b000) begin
      n_fail++; $display("FAIL load_use_x0 got %b want 000", {sif1, sid1, fex1});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_muldiv();
    longint c0;
    do_reset();
    c0 = cnt1;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 4; k++) begin
        MD_start_ex = 1'b1;
        #2;
        e1 = model(ph1, 4);
        e2 = model(ph2, 2);
        n_checks++;
        if ({sif1, sid1, sex1, fme1, done1} !== ((k < 3) ? 5'b11110 : 5'b00001)) begin
          n_fail++; $display("FAIL md_pattern rep=%0d k=%0d got %b", rep, k, {sif1, sid1, sex1, fme1, done1});
        end
        n_checks++;
        if (obs1 !== e1 || obs2 !== e2) begin
          n_fail++; $display("FAIL md_model k=%0d got %b/%b want %b/%b", k, obs1, obs2, e1, e2);
        end
        tick();
      end
      #2;
      n_checks++;
      if (cnt1_o !== 32'(c0 + 3 * (rep + 1))) begin
        n_fail++; $display("FAIL md_stall_cnt got %0d want %0d", cnt1_o, c0 + 3 * (rep + 1));
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    Branch_taken_ex = 1'b1; DMRd_ex = 1'b1; RUWr_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7;
    #2;
    n_checks++;
    if ({fid1, fex1, sif1, sid1} !== 4'b1100) begin
      n_fail++; $display("FAIL branch_vs_lu got %b want 1100", {fid1, fex1, sif1, sid1});
    end
    tick();
    clear_inputs();
    #2;
    n_checks++;
    if (cnt1_o !== 32'd0) begin n_fail++; $display("FAIL branch_cnt got %0d want 0", cnt1_o); end
    MD_start_ex = 1'b1;
    tick();
    Branch_taken_ex = 1'b1;
    #2;
    n_checks++;
    if ({fid1, fex1} !== 2'b00 || sex1 !== 1'b1) begin
      n_fail++; $display("FAIL branch_in_busy got flush=%b stall_ex=%b want 00/1", {fid1, fex1}, sex1);
    end
    tick(); tick(); tick();
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    do_reset();
    MD_start_ex = 1'b1;
    tick();
    rst = 1'b1;
    #2;
    n_checks++;
    if (obs1 !== 11'd0) begin n_fail++; $display("FAIL rst_busy_outputs got %b want 0", obs1); end
    tick();
    rst = 1'b0;
    MD_start_ex = 1'b0;
    #2;
    n_checks++;
    if (cnt1_o !== 32'd0 || obs1 !== 11'd0) begin
      n_fail++; $display("FAIL rst_busy_after got cnt=%0d out=%b want 0/0", cnt1_o, obs1);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      MD_start_ex = 1'b1;
      #2;
      n_checks++;
      if ({sex1, done1} !== ((k < 3) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rst_busy_restart k=%0d got %b", k, {sex1, done1});
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    DMRd_ex = 1'b1; RUWr_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5;
    for (int i = 0; i < 20; i++) tick();
    #2;
    n_checks++;
    if (cnt2_o !== 4'd15 || cnt1_o !== 32'd20) begin
      n_fail++; $display("FAIL sat_cnt got %0d/%0d want 15/20", cnt2_o, cnt1_o);
    end
    tick();
    #2;
    n_checks++;
    if (cnt2_o !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", cnt2_o); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3)); rd_me = 5'($urandom_range(0, 3));
      rd_wb = 5'($urandom_range(0, 3));
      RUWr_ex = 1'($urandom_range(0, 1)); RUWr_me = 1'($urandom_range(0, 1));
      RUWr_wb = 1'($urandom_range(0, 1)); DMRd_ex = 1'($urandom_range(0, 1));
      MD_start_ex = ($urandom_range(0, 5) == 0);
      Branch_taken_ex = ($urandom_range(0, 4) == 0);
      #2;
      e1 = model(ph1, 4);
      e2 = model(ph2, 2);
      n_checks++;
      if (obs1 !== e1 || obs2 !== e2) begin
        n_fail++; $display("FAIL random_out i=%0d got %b/%b want %b/%b", i, obs1, obs2, e1, e2);
      end
      n_checks++;
      if (cnt1_o !== 32'(cnt1) || cnt2_o !== 4'(cnt2)) begin
        n_fail++; $display("FAIL random_cnt i=%0d got %0d/%0d want %0d/%0d", i, cnt1_o, cnt2_o, cnt1, cnt2);
      end
      tick();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_muldiv();
    test_branch();
    test_reset_busy();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
